// File: rtl/boot_pkg.sv
// Shared types and constants for the boot_dma flash-to-RAM copier.
// The CHECK state exists only when BOOT_DMA_CHECKSUM_EN is defined.
package boot_pkg;

`ifdef BOOT_DMA_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } boot_state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd4
    } boot_state_t;
`endif

    localparam logic [23:0] DEFAULT_FLASH_BASE = 24'h040000;
    localparam logic [15:0] DEFAULT_RAM_BASE   = 16'h8000;

    // Byte-index width for a word of word_bytes bytes (at least one bit).
    function automatic int idx_width(input int word_bytes);
        return (word_bytes > 1) ? $clog2(word_bytes) : 1;
    endfunction

endpackage

// File: rtl/boot_word_unpacker.sv
// Holds one captured flash word and presents its bytes in little-endian order,
// one per accepted write; byte_o and last_byte_o are registered.
module boot_word_unpacker
    import boot_pkg::*;
#(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load_i,
    input  logic [8*WORD_BYTES-1:0] word_i,
    input  logic                    accept_i,
    output logic [7:0]              byte_o,
    output logic                    last_byte_o
);

    localparam int IDX_W = idx_width(WORD_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    logic [8*WORD_BYTES-1:0] word_q, word_d;
    logic [IDX_W-1:0]        idx_q, idx_d, nxt_idx_s;
    logic [7:0]              byte_q, byte_d;
    logic                    last_q, last_d;

    // Load a fresh word or step to the next byte on accept.
    always_comb begin
        word_d    = word_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        last_d    = last_q;
        nxt_idx_s = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        if (load_i) begin
            word_d = word_i;
            idx_d  = '0;
            byte_d = word_i[7:0];
            last_d = (WORD_BYTES == 1);
        end else if (accept_i) begin
            idx_d  = nxt_idx_s;
            byte_d = word_q[{nxt_idx_s, 3'b000} +: 8];
            last_d = (nxt_idx_s == LAST_IDX);
        end else begin
            idx_d = idx_q;
        end
    end

    // Word/byte registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            word_q <= '0;
            idx_q  <= '0;
            byte_q <= 8'h00;
            last_q <= 1'b0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            byte_q <= byte_d;
            last_q <= last_d;
        end
    end

    assign byte_o      = byte_q;
    assign last_byte_o = last_q;

endmodule

// File: rtl/boot_dma.sv
// Flash-to-RAM boot copier: fetches LENGTH bytes from flash and writes them to the bus.
// Optional BOOT_DMA_CHECKSUM_EN adds an 8-bit additive checksum verified against flash.
module boot_dma
    import boot_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter logic [23:0]       FLASH_BASE = DEFAULT_FLASH_BASE,
    parameter logic [ADDR_W-1:0] RAM_BASE   = ADDR_W'(DEFAULT_RAM_BASE),
    parameter int                LENGTH     = 32768,
    parameter int                WORD_BYTES = 4,
    parameter bit                AUTOBOOT   = 1'b1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    reboot_request,
    output logic                    booting,
    output logic                    boot_done,
    output logic                    boot_error,
    output logic                    boot_we,
    input  logic                    boot_ready,
    output logic [ADDR_W-1:0]       boot_address,
    output logic [7:0]              boot_data,
    output logic                    flash_valid,
    input  logic                    flash_ready,
    output logic [23:0]             flash_addr,
    input  logic [8*WORD_BYTES-1:0] flash_rdata
);

    localparam int                CNT_W       = $clog2(LENGTH + 1);
    localparam logic [CNT_W-1:0]  LEN_C       = CNT_W'(LENGTH);
    localparam logic [23:0]       WB_C        = 24'(WORD_BYTES);
    localparam boot_state_t       RESET_STATE = AUTOBOOT ? FETCH : IDLE;

    boot_state_t       state_q, state_d;
    logic              booting_q, booting_d;
    logic              we_q, we_d;
    logic              fvalid_q, fvalid_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic [23:0]       faddr_q, faddr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_s, flash_acc_s, byte_acc_s, last_s;
    logic [7:0]        byte_s;
`ifdef BOOT_DMA_CHECKSUM_EN
    logic              err_q, err_d;
    logic [7:0]        sum_q, sum_d;
`endif

    // flash_ready only counts while a request is actually outstanding.
    assign flash_acc_s = fvalid_q && flash_ready;
    assign byte_acc_s  = we_q && boot_ready;

    boot_word_unpacker #(
        .WORD_BYTES (WORD_BYTES)
    ) u_unpacker (
        .clk         (clk),
        .resetn      (resetn),
        .load_i      (load_s),
        .word_i      (flash_rdata),
        .accept_i    (byte_acc_s),
        .byte_o      (byte_s),
        .last_byte_o (last_s)
    );

    // Next-state logic; outputs are derived from the next state and registered.
    always_comb begin
        state_d = state_q;
        baddr_d = baddr_q;
        faddr_d = faddr_q;
        cnt_d   = cnt_q;
        load_s  = 1'b0;
`ifdef BOOT_DMA_CHECKSUM_EN
        err_d   = err_q;
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (reboot_request) begin
                    state_d = FETCH;
                    baddr_d = RAM_BASE;
                    faddr_d = FLASH_BASE;
                    cnt_d   = '0;
`ifdef BOOT_DMA_CHECKSUM_EN
                    err_d   = 1'b0;
                    sum_d   = 8'h00;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (flash_acc_s) begin
                    load_s  = 1'b1;
                    faddr_d = faddr_q + WB_C;
                    state_d = WRITE;
                end else begin
                    state_d = FETCH;
                end
            end
            WRITE: begin
                if (byte_acc_s) begin
                    baddr_d = baddr_q + ADDR_W'(1);
                    cnt_d   = cnt_q + CNT_W'(1);
`ifdef BOOT_DMA_CHECKSUM_EN
                    sum_d   = sum_q + byte_s;
`endif
                    // Leftover bytes of a partial final word are simply dropped.
                    if (cnt_d == LEN_C) begin
`ifdef BOOT_DMA_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else if (last_s) begin
                        state_d = FETCH;
                    end else begin
                        state_d = WRITE;
                    end
                end else begin
                    state_d = WRITE;
                end
            end
`ifdef BOOT_DMA_CHECKSUM_EN
            CHECK: begin
                // faddr already points at the word following the rounded-up image.
                if (flash_acc_s) begin
                    faddr_d = faddr_q + WB_C;
                    err_d   = (flash_rdata[7:0] != sum_q);
                    state_d = DONE;
                end else begin
                    state_d = CHECK;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

`ifdef BOOT_DMA_CHECKSUM_EN
        booting_d = (state_d == FETCH) || (state_d == WRITE) || (state_d == CHECK);
        fvalid_d  = (state_d == FETCH) || (state_d == CHECK);
`else
        booting_d = (state_d == FETCH) || (state_d == WRITE);
        fvalid_d  = (state_d == FETCH);
`endif
        we_d   = (state_d == WRITE);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= RESET_STATE;
            booting_q <= 1'b0;
            we_q      <= 1'b0;
            fvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            baddr_q   <= RAM_BASE;
            faddr_q   <= FLASH_BASE;
            cnt_q     <= '0;
`ifdef BOOT_DMA_CHECKSUM_EN
            err_q     <= 1'b0;
            sum_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            booting_q <= booting_d;
            we_q      <= we_d;
            fvalid_q  <= fvalid_d;
            done_q    <= done_d;
            baddr_q   <= baddr_d;
            faddr_q   <= faddr_d;
            cnt_q     <= cnt_d;
`ifdef BOOT_DMA_CHECKSUM_EN
            err_q     <= err_d;
            sum_q     <= sum_d;
`endif
        end
    end

    assign booting      = booting_q;
    assign boot_done    = done_q;
    assign boot_we      = we_q;
    assign boot_address = baddr_q;
    assign boot_data    = byte_s;
    assign flash_valid  = fvalid_q;
    assign flash_addr   = faddr_q;
`ifdef BOOT_DMA_CHECKSUM_EN
    assign boot_error   = err_q;
`else
    assign boot_error   = 1'b0;
`endif

endmodule
